elink_rec_collector: RTL and testbench
======================================

ELINK_REC_COLLECTOR -- requirements
Module: elink_rec_collector

Interface
REQ-001 SHALL have parameter WRITE_LATENCY, default 4: cycles from word capture to end_write_elink pulse (legal 1..15).
REQ-002 SHALL have parameter TIMEOUT, default 255: max cycles in WAIT_MSG before abort (legal 1..255).
REQ-003 SHALL have parameter FIFO_DEPTH, default 8: stored words, power of two, 2..32.
REQ-004 SHALL have ports: clk  in  1  rising-edge clock, the only clock.
REQ-005 SHALL have: rst  in  1  reset, synchronous, active-low.
REQ-006 SHALL have: start_write_elink  in  1  core opens a write transaction (1-cycle pulse).
REQ-007 SHALL have: send_mes_elink  in  1  data_rec_uplink valid this cycle.
REQ-008 SHALL have: data_rec_uplink  in  76  uplink word from core.
REQ-009 SHALL have: end_write_elink  out  1  1-cycle pulse, transaction complete.
REQ-010 SHALL have: rd_en  in  1  pop request; rd_data  out  76  popped word; rd_valid  out  1  rd_data valid pulse.
REQ-011 SHALL have: fifo_empty  out  1; fifo_full  out  1; msg_count  out  16  accepted words.
REQ-012 SHALL have: overflow_err  out  1  sticky; timeout_err  out  1  sticky; clr_err  in  1  clears both stickies.

Function
REQ-013 SHALL implement FSM IDLE, WAIT_MSG, LATENCY, DONE; exactly one state active.
REQ-014 IDLE: start_write_elink=1 -> WAIT_MSG next cycle; send_mes_elink in IDLE ignored.
REQ-015 WAIT_MSG: send_mes_elink=1 -> capture data_rec_uplink that cycle, load latency counter with WRITE_LATENCY-1, go LATENCY.
REQ-016 WAIT_MSG: timeout counter counts cycles in state; reaching TIMEOUT without send_mes_elink -> set timeout_err, go IDLE, no end_write_elink.
REQ-017 LATENCY: counter decrements each cycle; at 0 -> DONE; DONE asserts end_write_elink for exactly one cycle, then IDLE.
REQ-018 Total: end_write_elink high exactly WRITE_LATENCY+1 cycles after the capture edge.
REQ-019 start_write_elink outside IDLE SHALL be ignored (no restart, no error).
REQ-020 Capture with FIFO not full: word pushed, msg_count increments (16-bit, wraps 0xFFFF->0x0000).
REQ-021 Capture with FIFO full and no same-cycle pop: word dropped, overflow_err set, msg_count unchanged, end_write_elink still issued.
REQ-022 Capture with FIFO full and rd_en same cycle: pop and push both succeed, no overflow.
REQ-023 rd_en with FIFO non-empty: rd_data/rd_valid registered, valid one cycle after rd_en, FIFO order preserved.
REQ-024 rd_en with FIFO empty: ignored, rd_valid=0, rd_data holds last value.
REQ-025 fifo_empty/fifo_full SHALL reflect occupancy after the current edge (registered flags).
REQ-026 clr_err=1 clears both stickies; a set event in the same cycle SHALL win over clear.

Reset
REQ-027 rst=0 at a rising edge: state IDLE, counters 0, FIFO empty, fifo_empty=1, fifo_full=0, end_write_elink=0, rd_valid=0, rd_data=0, msg_count=0, both errors 0.
REQ-028 Reset mid-transaction SHALL abort it with no end_write_elink pulse and discard FIFO content.
REQ-029 Inputs SHALL be ignored during the cycle rst=0 is sampled.

Structure
REQ-030 Package elink_rec_pkg SHALL hold DATA_W=76, the FSM state enum, and counter width constants.
REQ-031 FIFO SHALL be a sub-module elink_rec_fifo (sync, single clock, registered read, full/empty flags); FSM and counters in top.

Verification
REQ-032 Single write: start pulse, send_mes_elink 2 cycles later with 0xA5...A5 -> end_write_elink 5 cycles after capture, msg_count=1, pop returns same word with rd_valid.
REQ-033 Timeout (TIMEOUT=10): start pulse, no send_mes_elink -> timeout_err at cycle 10, state IDLE, no end pulse; clr_err clears it.
REQ-034 Overflow: 9 writes, no pops (depth 8) -> 9th dropped, overflow_err=1, msg_count=8, fifo_full=1, 9 end pulses; pops return words 1..8 in order.
REQ-035 Full + simultaneous pop on capture -> no overflow, fifo_full stays 1, msg_count=9.
REQ-036 rst=0 during LATENCY -> no end pulse, fifo_empty=1, msg_count=0; next write completes normally.
REQ-037 start_write_elink repeated during LATENCY and rd_en on empty FIFO -> both ignored, one end pulse, rd_valid stays 0.

Source files
------------

// File: rtl/elink_rec_pkg.sv
// Shared widths, word type and FSM state encoding for the uplink record collector.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package elink_rec_pkg;

  localparam int DATA_W    = 76;
  localparam int LAT_CNT_W = 4;   // holds WRITE_LATENCY-1 for WRITE_LATENCY up to 15
  localparam int TO_CNT_W  = 8;   // holds TIMEOUT-1 for TIMEOUT up to 255
  localparam int MSG_CNT_W = 16;

  typedef logic [DATA_W-1:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_MSG = 2'd1,
    ST_LATENCY  = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

endpackage

// File: rtl/elink_rec_fifo.sv
// Synchronous single-clock word FIFO with registered read port and registered full/empty flags.
// Latency: pop_dat/pop_dat_vld one cycle after pop_vld; flags reflect occupancy after the edge.
// Backpressure: push refused when full unless a pop succeeds in the same cycle; pop on empty ignored.
module elink_rec_fifo
  import elink_rec_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push_vld,
  input  word_t push_dat,
  output logic  push_acc,
  input  logic  pop_vld,
  output word_t pop_dat,
  output logic  pop_dat_vld,
  output logic  empty,
  output logic  full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  word_t            mem_q [DEPTH];
  word_t            mem_d [DEPTH];
  word_t            rd_dat_q, rd_dat_d;
  logic             rd_vld_q, rd_vld_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;
  logic             pop_ok;
  logic             push_ok;

  // Next-state for pointers, storage, read register and occupancy flags
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    rd_dat_d = rd_dat_q;
    rd_vld_d = 1'b0;

    // A pop frees a slot this same edge, so a push into a full FIFO still fits
    pop_ok  = pop_vld && !empty_q;
    push_ok = push_vld && (!full_q || pop_ok);

    if (push_ok) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_dat_d = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + 1'b1;
      rd_vld_d = 1'b1;
    end

    cnt_d   = cnt_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    empty_d = (cnt_d == '0);
    full_d  = (cnt_d == CNT_W'(DEPTH));
  end

  // Control state with synchronous active-low reset; reset discards all stored words
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      rd_dat_q <= '0;
      rd_vld_q <= 1'b0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      rd_dat_q <= rd_dat_d;
      rd_vld_q <= rd_vld_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
    end
  end

  // Storage array needs no reset: pointers alone define which entries are live
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign push_acc    = push_ok;
  assign pop_dat     = rd_dat_q;
  assign pop_dat_vld = rd_vld_q;
  assign empty       = empty_q;
  assign full        = full_q;

endmodule

// File: rtl/elink_rec_collector.sv
// Collects one uplink word per write transaction into a FIFO and signals completion after a fixed latency.
// Latency: end_write_elink pulses WRITE_LATENCY+1 cycles after the capture edge; reads return one cycle after rd_en.
// Backpressure: none toward the core; a capture into a full FIFO is dropped and flagged in overflow_err.
module elink_rec_collector
  import elink_rec_pkg::*;
#(
  parameter int WRITE_LATENCY = 4,
  parameter int TIMEOUT       = 255,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_write_elink,
  input  logic                 send_mes_elink,
  input  logic [DATA_W-1:0]    data_rec_uplink,
  output logic                 end_write_elink,
  input  logic                 rd_en,
  output logic [DATA_W-1:0]    rd_data,
  output logic                 rd_valid,
  output logic                 fifo_empty,
  output logic                 fifo_full,
  output logic [MSG_CNT_W-1:0] msg_count,
  output logic                 overflow_err,
  output logic                 timeout_err,
  input  logic                 clr_err
);

  state_t                 state_q, state_d;
  logic [LAT_CNT_W-1:0]   lat_cnt_q, lat_cnt_d;
  logic [TO_CNT_W-1:0]    to_cnt_q, to_cnt_d;
  logic [MSG_CNT_W-1:0]   msg_cnt_q, msg_cnt_d;
  logic                   end_q, end_d;
  logic                   ovf_err_q, ovf_err_d;
  logic                   to_err_q, to_err_d;
  logic                   capture;
  logic                   to_expire;
  logic                   push_acc;

  elink_rec_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_vld    (capture),
    .push_dat    (data_rec_uplink),
    .push_acc    (push_acc),
    .pop_vld     (rd_en),
    .pop_dat     (rd_data),
    .pop_dat_vld (rd_valid),
    .empty       (fifo_empty),
    .full        (fifo_full)
  );

  // Transaction FSM: next state, latency/timeout counters and capture strobe
  always_comb begin
    state_d   = state_q;
    lat_cnt_d = lat_cnt_q;
    to_cnt_d  = to_cnt_q;
    capture   = 1'b0;
    to_expire = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // send_mes_elink has no meaning until a transaction is opened
        if (start_write_elink) begin
          state_d  = ST_WAIT_MSG;
          to_cnt_d = '0;
        end
      end
      ST_WAIT_MSG: begin
        // A word arriving on the last allowed cycle still wins over the timeout
        if (send_mes_elink) begin
          capture   = 1'b1;
          lat_cnt_d = LAT_CNT_W'(WRITE_LATENCY - 1);
          to_cnt_d  = '0;
          state_d   = ST_LATENCY;
        end else if (to_cnt_q == TO_CNT_W'(TIMEOUT - 1)) begin
          to_expire = 1'b1;
          to_cnt_d  = '0;
          state_d   = ST_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      ST_LATENCY: begin
        if (lat_cnt_q == '0) begin
          state_d = ST_DONE;
        end else begin
          lat_cnt_d = lat_cnt_q - 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Completion pulse, accepted-word count and sticky errors (a set beats a same-cycle clear)
  always_comb begin
    // Registering the DONE decode puts the pulse one cycle after DONE, i.e. WRITE_LATENCY+1 after capture
    end_d     = (state_q == ST_DONE);
    msg_cnt_d = msg_cnt_q + MSG_CNT_W'(push_acc);

    ovf_err_d = ovf_err_q;
    if (capture && !push_acc) begin
      ovf_err_d = 1'b1;
    end else if (clr_err) begin
      ovf_err_d = 1'b0;
    end

    to_err_d = to_err_q;
    if (to_expire) begin
      to_err_d = 1'b1;
    end else if (clr_err) begin
      to_err_d = 1'b0;
    end
  end

  // State and counter registers; reset aborts any open transaction without a completion pulse
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      lat_cnt_q <= '0;
      to_cnt_q  <= '0;
      msg_cnt_q <= '0;
      end_q     <= 1'b0;
      ovf_err_q <= 1'b0;
      to_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      lat_cnt_q <= lat_cnt_d;
      to_cnt_q  <= to_cnt_d;
      msg_cnt_q <= msg_cnt_d;
      end_q     <= end_d;
      ovf_err_q <= ovf_err_d;
      to_err_q  <= to_err_d;
    end
  end

  assign end_write_elink = end_q;
  assign msg_count       = msg_cnt_q;
  assign overflow_err    = ovf_err_q;
  assign timeout_err     = to_err_q;

endmodule

// File: tb/tb_elink_rec_collector.sv
// Directed bench for elink_rec_collector with queue-based scoreboard for end pulses and popped words.
// Latency: end pulse expected WRITE_LATENCY+1 cycles after capture; read data one cycle after rd_en.
// Backpressure: exercises full-FIFO drop, full-with-pop, empty pop, timeout and mid-transaction reset.
module tb_elink_rec_collector;

  localparam int WL    = 4;
  localparam int TO    = 10;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_write_elink = 1'b0;
  logic        send_mes_elink = 1'b0;
  logic [75:0] data_rec_uplink = '0;
  logic        end_write_elink;
  logic        rd_en = 1'b0;
  logic [75:0] rd_data;
  logic        rd_valid;
  logic        fifo_empty;
  logic        fifo_full;
  logic [15:0] msg_count;
  logic        overflow_err;
  logic        timeout_err;
  logic        clr_err = 1'b0;

  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  int          end_seen = 0;
  int          exp_end[$];
  logic [75:0] exp_rd[$];
  logic [75:0] mdl[$];

  localparam logic [75:0] W_A5 = {4'h5, {9{8'hA5}}};

  elink_rec_collector #(
    .WRITE_LATENCY (WL),
    .TIMEOUT       (TO),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .start_write_elink (start_write_elink),
    .send_mes_elink    (send_mes_elink),
    .data_rec_uplink   (data_rec_uplink),
    .end_write_elink   (end_write_elink),
    .rd_en             (rd_en),
    .rd_data           (rd_data),
    .rd_valid          (rd_valid),
    .fifo_empty        (fifo_empty),
    .fifo_full         (fifo_full),
    .msg_count         (msg_count),
    .overflow_err      (overflow_err),
    .timeout_err       (timeout_err),
    .clr_err           (clr_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [75:0] mkw(input int k);
    return {{9{8'(k)}}, 4'hC};
  endfunction

  task automatic chk(input string name, input logic [75:0] act, input logic [75:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops expectations whenever the DUT presents an end pulse or read data
  always @(negedge clk) begin
    if (end_write_elink) begin
      end_seen++;
      if (exp_end.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL end_unexpected: pulse at cycle %0d, none expected", cyc);
      end else begin
        chk("end_cycle", 76'(cyc), 76'(exp_end.pop_front()));
      end
    end
    if (rd_valid) begin
      if (exp_rd.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL rd_unexpected: rd_data %0h at cycle %0d, none expected", rd_data, cyc);
      end else begin
        chk("rd_data", rd_data, exp_rd.pop_front());
      end
    end
  end

  task automatic do_reset();
    rst = 1'b0;
    mdl.delete();
    tick();
    tick();
    rst = 1'b1;
  endtask

  // Full transaction: start, one idle cycle, capture, then wait until back in IDLE
  task automatic write_word(input logic [75:0] w, input bit pop_same, input bit clr);
    start_write_elink = 1'b1;
    tick();
    start_write_elink = 1'b0;
    tick();
    send_mes_elink  = 1'b1;
    data_rec_uplink = w;
    rd_en           = pop_same;
    clr_err         = clr;
    if (pop_same && mdl.size() > 0) exp_rd.push_back(mdl.pop_front());
    if (mdl.size() < DEPTH) mdl.push_back(w);
    tick();
    exp_end.push_back(cyc + WL + 1);
    send_mes_elink = 1'b0;
    rd_en          = 1'b0;
    clr_err        = 1'b0;
    repeat (WL + 1) tick();
  endtask

  task automatic pop_n(input int n);
    rd_en = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (mdl.size() > 0) exp_rd.push_back(mdl.pop_front());
      tick();
    end
    rd_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;

    // Reset state
    do_reset();
    chk("rst_fifo_empty", 76'(fifo_empty), 76'(1));
    chk("rst_fifo_full", 76'(fifo_full), 76'(0));
    chk("rst_msg_count", 76'(msg_count), 76'(0));
    chk("rst_end", 76'(end_write_elink), 76'(0));
    chk("rst_rd_valid", 76'(rd_valid), 76'(0));
    chk("rst_rd_data", rd_data, 76'(0));
    chk("rst_ovf", 76'(overflow_err), 76'(0));
    chk("rst_to", 76'(timeout_err), 76'(0));

    // Single write and read-back
    write_word(W_A5, 1'b0, 1'b0);
    chk("single_msg_count", 76'(msg_count), 76'(1));
    chk("single_not_empty", 76'(fifo_empty), 76'(0));
    pop_n(1);
    tick();
    chk("single_empty_after_pop", 76'(fifo_empty), 76'(1));

    // Pop on empty FIFO and repeated start during LATENCY are both ignored
    start_write_elink = 1'b1;
    tick();
    start_write_elink = 1'b0;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("empty_pop_no_valid", 76'(rd_valid), 76'(0));
    chk("empty_pop_data_held", rd_data, W_A5);
    send_mes_elink  = 1'b1;
    data_rec_uplink = mkw(2);
    mdl.push_back(mkw(2));
    tick();
    exp_end.push_back(cyc + WL + 1);
    send_mes_elink    = 1'b0;
    start_write_elink = 1'b1;
    tick();
    start_write_elink = 1'b0;
    repeat (WL + 3) tick();
    chk("restart_msg_count", 76'(msg_count), 76'(2));
    pop_n(1);

    // Timeout with no word: error after exactly TO cycles in WAIT_MSG, then clear
    start_write_elink = 1'b1;
    tick();
    start_write_elink = 1'b0;
    repeat (TO - 1) tick();
    chk("to_not_yet", 76'(timeout_err), 76'(0));
    tick();
    chk("to_set", 76'(timeout_err), 76'(1));
    send_mes_elink = 1'b1;
    tick();
    send_mes_elink = 1'b0;
    tick();
    chk("to_idle_send_ignored", 76'(msg_count), 76'(2));
    chk("to_idle_fifo_empty", 76'(fifo_empty), 76'(1));
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("to_cleared", 76'(timeout_err), 76'(0));

    // Overflow: 9 writes into a depth-8 FIFO; 9th also has clr_err (set must win)
    do_reset();
    e0 = end_seen;
    for (int k = 1; k <= 8; k++) write_word(mkw(k), 1'b0, 1'b0);
    chk("ovf_full_at_8", 76'(fifo_full), 76'(1));
    chk("ovf_not_yet", 76'(overflow_err), 76'(0));
    write_word(mkw(9), 1'b0, 1'b1);
    tick();
    chk("ovf_set", 76'(overflow_err), 76'(1));
    chk("ovf_msg_count", 76'(msg_count), 76'(8));
    chk("ovf_still_full", 76'(fifo_full), 76'(1));
    chk("ovf_end_pulses", 76'(end_seen - e0), 76'(9));
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("ovf_cleared", 76'(overflow_err), 76'(0));

    // Full FIFO with simultaneous pop on capture: both succeed
    write_word(mkw(10), 1'b1, 1'b0);
    chk("fullpop_no_ovf", 76'(overflow_err), 76'(0));
    chk("fullpop_full", 76'(fifo_full), 76'(1));
    chk("fullpop_msg_count", 76'(msg_count), 76'(9));
    pop_n(8);
    tick();
    chk("drain_empty", 76'(fifo_empty), 76'(1));

    // Reset during LATENCY aborts the transaction
    start_write_elink = 1'b1;
    tick();
    start_write_elink = 1'b0;
    tick();
    send_mes_elink  = 1'b1;
    data_rec_uplink = mkw(11);
    tick();
    send_mes_elink = 1'b0;
    tick();
    tick();
    do_reset();
    chk("midrst_empty", 76'(fifo_empty), 76'(1));
    chk("midrst_msg_count", 76'(msg_count), 76'(0));
    repeat (WL + 3) tick();
    write_word(mkw(12), 1'b0, 1'b0);
    chk("post_rst_msg_count", 76'(msg_count), 76'(1));
    pop_n(1);

    repeat (4) tick();
    chk("end_queue_drained", 76'(exp_end.size()), 76'(0));
    chk("rd_queue_drained", 76'(exp_rd.size()), 76'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
